// File: rtl/stg_ma_pkg.sv
// stg_ma_pkg: shared widths, memory-op encodings and FSM state codes for the
// memory-access stage (stg_ma) and its bus sequencer (stg_ma_mem_bus_fsm).
package stg_ma_pkg;

  // Datapath widths
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int OPC_W    = 8;
  localparam int TGT_GP_W = 4;
  localparam int TGT_SR_W = 2;
  localparam int TGT_AR_W = 2;

  // Memory operation encodings (2'b11 is treated as no access)
  localparam int SIZE_MEMOP = 2;
  localparam logic [SIZE_MEMOP-1:0] MEMOP_NONE  = 2'b00;
  localparam logic [SIZE_MEMOP-1:0] MEMOP_LOAD  = 2'b01;
  localparam logic [SIZE_MEMOP-1:0] MEMOP_STORE = 2'b10;

  // Bus sequencer states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // True when the op actually touches the data bus
  function automatic logic memop_is_access(input logic [SIZE_MEMOP-1:0] op);
    return (op == MEMOP_LOAD) || (op == MEMOP_STORE);
  endfunction

endpackage

// File: rtl/stg_ma_mem_bus_fsm.sv
// stg_ma_mem_bus_fsm: issues one request on the ready-based data bus, holds
// address/data/we stable until ready, tracks a kill flag for flushes that
// arrive while the bus cannot be aborted, and produces completion pulses.
// Optional bus-wait timeout: define STG_MA_TIMEOUT_EN.
module stg_ma_mem_bus_fsm
  import stg_ma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_issue,
  input  logic              iw_is_store,
  input  logic [ADDR_W-1:0] iw_addr,
  input  logic [DATA_W-1:0] iw_wdata,
  input  logic              iw_flush,
  input  logic              iw_mem_ready,
  input  logic              iw_mem_err,
  output logic              ow_mem_req,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  output logic              ow_busy,
  output logic              ow_done,
  output logic              ow_done_err,
  output logic              ow_stall
);

  logic [0:0]        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_kill;

  logic w_wait;
  logic w_timeout;
  logic w_complete;
  logic w_kill;
  logic w_err;

  assign w_wait     = (r_state == ST_WAIT);
  assign w_complete = w_wait && (iw_mem_ready || w_timeout);
  // A flush in the completing cycle kills the access just like an earlier one
  assign w_kill     = r_kill || iw_flush;
  // Ready wins over a coincident timeout; otherwise a timeout is an error
  assign w_err      = iw_mem_ready ? iw_mem_err : w_timeout;

  assign ow_mem_req   = w_wait;
  assign ow_mem_we    = w_wait && r_we;
  assign ow_mem_addr  = r_addr;
  assign ow_mem_wdata = r_wdata;
  assign ow_busy      = w_wait;
  assign ow_done      = w_complete && !w_kill && !w_err;
  assign ow_done_err  = w_complete && !w_kill && w_err;
  assign ow_stall     = iw_issue || (w_wait && !w_complete);

`ifdef STG_MA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count WAIT cycles; the last allowed cycle completes as an error
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_cnt <= '0;
    end else if (iw_issue) begin
      r_cnt <= '0;
    end else if (w_wait && !w_complete) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = w_wait && (r_cnt == CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Request registers, state and kill flag
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_kill  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iw_issue) begin
            r_state <= ST_WAIT;
            r_we    <= iw_is_store;
            r_addr  <= iw_addr;
            r_wdata <= iw_wdata;
            r_kill  <= 1'b0;
          end
        end
        default: begin
          if (w_complete) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_kill  <= 1'b0;
          end else if (iw_flush) begin
            r_kill  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/stg_ma.sv
// stg_ma: memory-access pipeline stage. Passes non-memory instructions to
// writeback in one cycle, sequences loads/stores through stg_ma_mem_bus_fsm
// while stalling the front of the pipe, and muxes load data into the result.
// Optional bus-wait timeout: define STG_MA_TIMEOUT_EN.
module stg_ma
  import stg_ma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic [ADDR_W-1:0]     iw_pc,
  input  logic [DATA_W-1:0]     iw_instr,
  input  logic [OPC_W-1:0]      iw_opc,
  input  logic [OPC_W-1:0]      iw_root_opc,
  input  logic [TGT_GP_W-1:0]   iw_tgt_gp,
  input  logic                  iw_tgt_gp_we,
  input  logic [TGT_SR_W-1:0]   iw_tgt_sr,
  input  logic                  iw_tgt_sr_we,
  input  logic [TGT_AR_W-1:0]   iw_tgt_ar,
  input  logic                  iw_tgt_ar_we,
  input  logic [DATA_W-1:0]     iw_result,
  input  logic [ADDR_W-1:0]     iw_sr_result,
  input  logic [ADDR_W-1:0]     iw_ar_result,
  input  logic                  iw_trap_pending,
  input  logic [SIZE_MEMOP-1:0] iw_mem_op,
  input  logic [ADDR_W-1:0]     iw_mem_addr,
  input  logic [DATA_W-1:0]     iw_mem_wdata,
  input  logic                  iw_flush,
  output logic                  ow_mem_req,
  output logic                  ow_mem_we,
  output logic [ADDR_W-1:0]     ow_mem_addr,
  output logic [DATA_W-1:0]     ow_mem_wdata,
  input  logic                  iw_mem_ready,
  input  logic [DATA_W-1:0]     iw_mem_rdata,
  input  logic                  iw_mem_err,
  output logic                  ow_stall,
  output logic [ADDR_W-1:0]     ow_pc,
  output logic [DATA_W-1:0]     ow_instr,
  output logic [OPC_W-1:0]      ow_opc,
  output logic [OPC_W-1:0]      ow_root_opc,
  output logic [TGT_GP_W-1:0]   ow_tgt_gp,
  output logic                  ow_tgt_gp_we,
  output logic [TGT_SR_W-1:0]   ow_tgt_sr,
  output logic                  ow_tgt_sr_we,
  output logic [TGT_AR_W-1:0]   ow_tgt_ar,
  output logic                  ow_tgt_ar_we,
  output logic [DATA_W-1:0]     ow_result,
  output logic [ADDR_W-1:0]     ow_sr_result,
  output logic [ADDR_W-1:0]     ow_ar_result,
  output logic                  ow_trap_pending
);

  logic              w_busy;
  logic              w_done;
  logic              w_done_err;
  logic              w_issue;
  logic              w_we_en;
  logic              w_trap_next;
  logic [DATA_W-1:0] w_result_next;

  // Trapping or flushed instructions never reach the bus
  assign w_issue = !w_busy && memop_is_access(iw_mem_op) && !iw_trap_pending && !iw_flush;

  stg_ma_mem_bus_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus (
    .iw_clk       (iw_clk),
    .iw_rst       (iw_rst),
    .iw_issue     (w_issue),
    .iw_is_store  (iw_mem_op == MEMOP_STORE),
    .iw_addr      (iw_mem_addr),
    .iw_wdata     (iw_mem_wdata),
    .iw_flush     (iw_flush),
    .iw_mem_ready (iw_mem_ready),
    .iw_mem_err   (iw_mem_err),
    .ow_mem_req   (ow_mem_req),
    .ow_mem_we    (ow_mem_we),
    .ow_mem_addr  (ow_mem_addr),
    .ow_mem_wdata (ow_mem_wdata),
    .ow_busy      (w_busy),
    .ow_done      (w_done),
    .ow_done_err  (w_done_err),
    .ow_stall     (ow_stall)
  );

  // Decide write enables, trap and result for the bundle latched this cycle;
  // anything other than a clean pass or a clean completion is a bubble
  always_comb begin
    w_we_en       = 1'b1;
    w_trap_next   = iw_trap_pending;
    w_result_next = iw_result;
    if (w_busy) begin
      if (w_done) begin
        if (iw_mem_op == MEMOP_LOAD) begin
          w_result_next = iw_mem_rdata;
        end
      end else if (w_done_err) begin
        w_we_en     = 1'b0;
        w_trap_next = 1'b1;
      end else begin
        w_we_en     = 1'b0;
        w_trap_next = 1'b0;
      end
    end else if (iw_flush || w_issue) begin
      w_we_en     = 1'b0;
      w_trap_next = 1'b0;
    end
  end

  // Output latch feeding writeback
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      ow_pc           <= '0;
      ow_instr        <= '0;
      ow_opc          <= '0;
      ow_root_opc     <= '0;
      ow_tgt_gp       <= '0;
      ow_tgt_gp_we    <= 1'b0;
      ow_tgt_sr       <= '0;
      ow_tgt_sr_we    <= 1'b0;
      ow_tgt_ar       <= '0;
      ow_tgt_ar_we    <= 1'b0;
      ow_result       <= '0;
      ow_sr_result    <= '0;
      ow_ar_result    <= '0;
      ow_trap_pending <= 1'b0;
    end else begin
      ow_pc           <= iw_pc;
      ow_instr        <= iw_instr;
      ow_opc          <= iw_opc;
      ow_root_opc     <= iw_root_opc;
      ow_tgt_gp       <= iw_tgt_gp;
      ow_tgt_gp_we    <= iw_tgt_gp_we && w_we_en;
      ow_tgt_sr       <= iw_tgt_sr;
      ow_tgt_sr_we    <= iw_tgt_sr_we && w_we_en;
      ow_tgt_ar       <= iw_tgt_ar;
      ow_tgt_ar_we    <= iw_tgt_ar_we && w_we_en;
      ow_result       <= w_result_next;
      ow_sr_result    <= iw_sr_result;
      ow_ar_result    <= iw_ar_result;
      ow_trap_pending <= w_trap_next;
    end
  end

endmodule

// File: tb/tb_stg_ma.sv
// tb_stg_ma: directed-vector bench for the memory-access stage.
// Build with STG_MA_TIMEOUT_EN defined to also exercise the bus-wait timeout.
module tb_stg_ma;
  import stg_ma_pkg::*;

  logic                  iw_clk = 1'b0;
  logic                  iw_rst = 1'b1;
  logic [ADDR_W-1:0]     iw_pc = '0;
  logic [DATA_W-1:0]     iw_instr = '0;
  logic [OPC_W-1:0]      iw_opc = '0;
  logic [OPC_W-1:0]      iw_root_opc = '0;
  logic [TGT_GP_W-1:0]   iw_tgt_gp = '0;
  logic                  iw_tgt_gp_we = 1'b0;
  logic [TGT_SR_W-1:0]   iw_tgt_sr = '0;
  logic                  iw_tgt_sr_we = 1'b0;
  logic [TGT_AR_W-1:0]   iw_tgt_ar = '0;
  logic                  iw_tgt_ar_we = 1'b0;
  logic [DATA_W-1:0]     iw_result = '0;
  logic [ADDR_W-1:0]     iw_sr_result = '0;
  logic [ADDR_W-1:0]     iw_ar_result = '0;
  logic                  iw_trap_pending = 1'b0;
  logic [SIZE_MEMOP-1:0] iw_mem_op = '0;
  logic [ADDR_W-1:0]     iw_mem_addr = '0;
  logic [DATA_W-1:0]     iw_mem_wdata = '0;
  logic                  iw_flush = 1'b0;
  logic                  iw_mem_ready = 1'b0;
  logic [DATA_W-1:0]     iw_mem_rdata = '0;
  logic                  iw_mem_err = 1'b0;

  logic                  ow_mem_req;
  logic                  ow_mem_we;
  logic [ADDR_W-1:0]     ow_mem_addr;
  logic [DATA_W-1:0]     ow_mem_wdata;
  logic                  ow_stall;
  logic [ADDR_W-1:0]     ow_pc;
  logic [DATA_W-1:0]     ow_instr;
  logic [OPC_W-1:0]      ow_opc;
  logic [OPC_W-1:0]      ow_root_opc;
  logic [TGT_GP_W-1:0]   ow_tgt_gp;
  logic                  ow_tgt_gp_we;
  logic [TGT_SR_W-1:0]   ow_tgt_sr;
  logic                  ow_tgt_sr_we;
  logic [TGT_AR_W-1:0]   ow_tgt_ar;
  logic                  ow_tgt_ar_we;
  logic [DATA_W-1:0]     ow_result;
  logic [ADDR_W-1:0]     ow_sr_result;
  logic [ADDR_W-1:0]     ow_ar_result;
  logic                  ow_trap_pending;

  int n_checks = 0;
  int n_fail   = 0;

  stg_ma #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .iw_clk          (iw_clk),
    .iw_rst          (iw_rst),
    .iw_pc           (iw_pc),
    .iw_instr        (iw_instr),
    .iw_opc          (iw_opc),
    .iw_root_opc     (iw_root_opc),
    .iw_tgt_gp       (iw_tgt_gp),
    .iw_tgt_gp_we    (iw_tgt_gp_we),
    .iw_tgt_sr       (iw_tgt_sr),
    .iw_tgt_sr_we    (iw_tgt_sr_we),
    .iw_tgt_ar       (iw_tgt_ar),
    .iw_tgt_ar_we    (iw_tgt_ar_we),
    .iw_result       (iw_result),
    .iw_sr_result    (iw_sr_result),
    .iw_ar_result    (iw_ar_result),
    .iw_trap_pending (iw_trap_pending),
    .iw_mem_op       (iw_mem_op),
    .iw_mem_addr     (iw_mem_addr),
    .iw_mem_wdata    (iw_mem_wdata),
    .iw_flush        (iw_flush),
    .ow_mem_req      (ow_mem_req),
    .ow_mem_we       (ow_mem_we),
    .ow_mem_addr     (ow_mem_addr),
    .ow_mem_wdata    (ow_mem_wdata),
    .iw_mem_ready    (iw_mem_ready),
    .iw_mem_rdata    (iw_mem_rdata),
    .iw_mem_err      (iw_mem_err),
    .ow_stall        (ow_stall),
    .ow_pc           (ow_pc),
    .ow_instr        (ow_instr),
    .ow_opc          (ow_opc),
    .ow_root_opc     (ow_root_opc),
    .ow_tgt_gp       (ow_tgt_gp),
    .ow_tgt_gp_we    (ow_tgt_gp_we),
    .ow_tgt_sr       (ow_tgt_sr),
    .ow_tgt_sr_we    (ow_tgt_sr_we),
    .ow_tgt_ar       (ow_tgt_ar),
    .ow_tgt_ar_we    (ow_tgt_ar_we),
    .ow_result       (ow_result),
    .ow_sr_result    (ow_sr_result),
    .ow_ar_result    (ow_ar_result),
    .ow_trap_pending (ow_trap_pending)
  );

  always #5 iw_clk = ~iw_clk;

  // Single comparison point: counts and reports one line per mismatch
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  // Return inputs to an idle non-memory instruction
  task automatic idle_inputs();
    iw_mem_op    = MEMOP_NONE;
    iw_tgt_gp_we = 1'b0;
    iw_tgt_sr_we = 1'b0;
    iw_tgt_ar_we = 1'b0;
    iw_flush     = 1'b0;
    iw_mem_ready = 1'b0;
    iw_mem_err   = 1'b0;
    iw_trap_pending = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    tick();
    chk("rst_req", 32'(ow_mem_req), 32'd0);
    chk("rst_result", ow_result, 32'd0);
    chk("rst_trap", 32'(ow_trap_pending), 32'd0);
    chk("rst_stall", 32'(ow_stall), 32'd0);
    iw_rst = 1'b0;
    tick();

    // ---- ALU op passes through in one cycle ----
    iw_mem_op = MEMOP_NONE; iw_result = 32'h123; iw_tgt_gp_we = 1'b1;
    iw_tgt_gp = 4'd5; iw_pc = 32'h100;
    #1;
    chk("alu_stall", 32'(ow_stall), 32'd0);
    tick();
    $display("txn alu: result=0x%0h gp_we=%0d", ow_result, ow_tgt_gp_we);
    chk("alu_result", ow_result, 32'h123);
    chk("alu_gp_we", 32'(ow_tgt_gp_we), 32'd1);
    chk("alu_tgt_gp", 32'(ow_tgt_gp), 32'd5);
    chk("alu_pc", ow_pc, 32'h100);
    idle_inputs();
    tick();

    // ---- load, ready after 3 wait cycles ----
    iw_mem_op = MEMOP_LOAD; iw_mem_addr = 32'h40; iw_result = 32'h999;
    iw_tgt_gp_we = 1'b1;
    #1;
    chk("ld_issue_stall", 32'(ow_stall), 32'd1);
    chk("ld_issue_noreq", 32'(ow_mem_req), 32'd0);
    tick();
    chk("ld_bubble_we", 32'(ow_tgt_gp_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait_req", 32'(ow_mem_req), 32'd1);
      chk("ld_wait_addr", ow_mem_addr, 32'h40);
      chk("ld_wait_we", 32'(ow_mem_we), 32'd0);
      chk("ld_wait_stall", 32'(ow_stall), 32'd1);
      tick();
    end
    iw_mem_ready = 1'b1; iw_mem_rdata = 32'hABC;
    #1;
    chk("ld_ready_stall", 32'(ow_stall), 32'd0);
    chk("ld_ready_addr", ow_mem_addr, 32'h40);
    tick();
    $display("txn load: result=0x%0h gp_we=%0d trap=%0d", ow_result, ow_tgt_gp_we, ow_trap_pending);
    chk("ld_result", ow_result, 32'hABC);
    chk("ld_gp_we", 32'(ow_tgt_gp_we), 32'd1);
    chk("ld_req_drop", 32'(ow_mem_req), 32'd0);
    chk("ld_trap", 32'(ow_trap_pending), 32'd0);
    idle_inputs();
    tick();

    // ---- store, immediate ready ----
    iw_mem_op = MEMOP_STORE; iw_mem_addr = 32'h10; iw_mem_wdata = 32'h55;
    iw_result = 32'h777;
    tick();
    chk("st_req", 32'(ow_mem_req), 32'd1);
    chk("st_we", 32'(ow_mem_we), 32'd1);
    chk("st_wdata", ow_mem_wdata, 32'h55);
    chk("st_addr", ow_mem_addr, 32'h10);
    iw_mem_ready = 1'b1;
    #1;
    chk("st_stall", 32'(ow_stall), 32'd0);
    tick();
    $display("txn store: result=0x%0h gp_we=%0d mem_we=%0d", ow_result, ow_tgt_gp_we, ow_mem_we);
    chk("st_we_drop", 32'(ow_mem_we), 32'd0);
    chk("st_gp_we", 32'(ow_tgt_gp_we), 32'd0);
    chk("st_result", ow_result, 32'h777);
    idle_inputs();
    tick();

    // ---- load completing with bus error ----
    iw_mem_op = MEMOP_LOAD; iw_mem_addr = 32'h80;
    iw_tgt_gp_we = 1'b1; iw_tgt_sr_we = 1'b1; iw_tgt_ar_we = 1'b1;
    tick();
    iw_mem_ready = 1'b1; iw_mem_err = 1'b1; iw_mem_rdata = 32'h5;
    tick();
    $display("txn load_err: trap=%0d we=%0d%0d%0d", ow_trap_pending, ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we);
    chk("err_trap", 32'(ow_trap_pending), 32'd1);
    chk("err_gp_we", 32'(ow_tgt_gp_we), 32'd0);
    chk("err_sr_we", 32'(ow_tgt_sr_we), 32'd0);
    chk("err_ar_we", 32'(ow_tgt_ar_we), 32'd0);
    idle_inputs();
    tick();
    chk("err_trap_clear", 32'(ow_trap_pending), 32'd0);

    // ---- flush during second WAIT cycle ----
    iw_mem_op = MEMOP_LOAD; iw_mem_addr = 32'h44; iw_tgt_gp_we = 1'b1;
    tick();
    tick();
    iw_flush = 1'b1;
    #1;
    chk("fl_stall", 32'(ow_stall), 32'd1);
    tick();
    iw_flush = 1'b0;
    #1;
    chk("fl_req_held", 32'(ow_mem_req), 32'd1);
    chk("fl_addr_held", ow_mem_addr, 32'h44);
    iw_mem_ready = 1'b1; iw_mem_err = 1'b1; iw_mem_rdata = 32'hDEAD;
    tick();
    $display("txn flush_wait: gp_we=%0d trap=%0d req=%0d", ow_tgt_gp_we, ow_trap_pending, ow_mem_req);
    chk("fl_gp_we", 32'(ow_tgt_gp_we), 32'd0);
    chk("fl_trap", 32'(ow_trap_pending), 32'd0);
    chk("fl_req_drop", 32'(ow_mem_req), 32'd0);
    idle_inputs();
    tick();

    // ---- flush and ready in the same cycle ----
    iw_mem_op = MEMOP_LOAD; iw_mem_addr = 32'h48; iw_tgt_gp_we = 1'b1;
    tick();
    iw_mem_ready = 1'b1; iw_flush = 1'b1; iw_mem_rdata = 32'h1234;
    tick();
    $display("txn flush_ready: gp_we=%0d trap=%0d", ow_tgt_gp_we, ow_trap_pending);
    chk("flr_gp_we", 32'(ow_tgt_gp_we), 32'd0);
    chk("flr_trap", 32'(ow_trap_pending), 32'd0);
    chk("flr_req", 32'(ow_mem_req), 32'd0);
    idle_inputs();
    tick();

    // ---- trapping instruction with mem op issues nothing ----
    iw_mem_op = MEMOP_LOAD; iw_trap_pending = 1'b1; iw_result = 32'h31;
    #1;
    chk("trp_stall", 32'(ow_stall), 32'd0);
    tick();
    chk("trp_req", 32'(ow_mem_req), 32'd0);
    chk("trp_out", 32'(ow_trap_pending), 32'd1);
    idle_inputs();
    tick();

`ifdef STG_MA_TIMEOUT_EN
    // ---- timeout after 4 WAIT cycles, later ready ignored ----
    iw_mem_op = MEMOP_LOAD; iw_mem_addr = 32'h60; iw_tgt_gp_we = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("to_wait_stall", 32'(ow_stall), 32'd1);
      tick();
    end
    chk("to_last_req", 32'(ow_mem_req), 32'd1);
    chk("to_last_stall", 32'(ow_stall), 32'd0);
    tick();
    $display("txn timeout: trap=%0d req=%0d gp_we=%0d", ow_trap_pending, ow_mem_req, ow_tgt_gp_we);
    chk("to_trap", 32'(ow_trap_pending), 32'd1);
    chk("to_req", 32'(ow_mem_req), 32'd0);
    chk("to_gp_we", 32'(ow_tgt_gp_we), 32'd0);
    idle_inputs();
    iw_mem_ready = 1'b1;
    tick();
    chk("to_late_ready_req", 32'(ow_mem_req), 32'd0);
    idle_inputs();
    tick();
`endif

    // ---- reset asserted mid-WAIT ----
    iw_mem_op = MEMOP_LOAD; iw_mem_addr = 32'h70; iw_tgt_gp_we = 1'b1;
    tick();
    chk("rw_req_before", 32'(ow_mem_req), 32'd1);
    iw_rst = 1'b1;
    #1;
    $display("txn reset_wait: req=%0d", ow_mem_req);
    chk("rw_req_async", 32'(ow_mem_req), 32'd0);
    chk("rw_gp_we", 32'(ow_tgt_gp_we), 32'd0);
    idle_inputs();
    tick();
    iw_rst = 1'b0;
    tick();
    chk("rw_idle_req", 32'(ow_mem_req), 32'd0);
    chk("rw_idle_stall", 32'(ow_stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
